operand_stage: RTL and testbench
================================

// Module: operand_stage
// PURPOSE
//   Decode-to-execute pipeline register for the 5-stage RV32I core. It captures the
//   source operands read from the register file, together with rs1/rs2/rd and control
//   bits, under a valid/ready handshake. It forwards MEM and WB results into operands
//   at capture, and refreshes held operands while stalled. It detects load-use hazards
//   and inserts a bubble.
// PARAMETERS
//   N   32   datapath / register width
// PORTS
//   clk           in   1  core clock; all state updates on posedge
//   rst           in   1  synchronous, active-high reset
//   in_valid      in   1  decode holds a valid instruction
//   in_ready      out  1  stage accepts decode's instruction this cycle
//   in_rs1        in   5  source register 1 index
//   in_rs2        in   5  source register 2 index
//   in_rd         in   5  destination register index
//   in_regwrite   in   1  instruction writes rd
//   in_memread    in   1  instruction is a load
//   in_rdata1     in   N  register file read port 1 data
//   in_rdata2     in   N  register file read port 2 data
//   flush         in   1  kill held and incoming instruction (branch redirect)
//   mem_regwrite  in   1  MEM stage writes mem_rd
//   mem_rd        in   5  MEM stage destination
//   mem_result    in   N  MEM stage ALU result
//   wb_regwrite   in   1  WB stage writes wb_rd
//   wb_rd         in   5  WB stage destination
//   wb_result     in   N  WB stage write data
//   ex_ready      in   1  execute accepts the held instruction
//   out_valid     out  1  held instruction valid
//   out_rs1/out_rs2/out_rd  out 5 each  held indices
//   out_regwrite, out_memread  out 1 each  held control bits
//   out_op1, out_op2  out  N  held operands (forwarded/refreshed)
//   load_use_stall out 1  combinational hazard flag to fetch/decode
// BEHAVIOUR
//   Reset: out_valid=0; all out_* registers=0; load_use_stall=0 (derived from out_valid).
//   fire_out = out_valid & ex_ready; fire_in = in_valid & in_ready.
//   load_use_stall = out_valid & out_memread & out_rd!=0 & in_valid &
//                    (in_rs1==out_rd | in_rs2==out_rd).
//   in_ready = (!out_valid | ex_ready) & !load_use_stall & !flush.
//   Posedge priority: rst > flush > capture > bubble/drain > hold.
//     flush: out_valid<=0 next edge; incoming instruction dropped.
//     fire_in: latch all fields; out_valid<=1 (latency 1 cycle).
//     fire_out & !fire_in (incl. load-use): out_valid<=0 (bubble).
//     out_valid & !ex_ready: hold all fields, except the refresh rule below.
//   Operand select at capture, per source s with index rs:
//     rs==0 -> 0; else mem_regwrite & mem_rd==rs -> mem_result;
//     else wb_regwrite & wb_rd==rs -> wb_result; else in_rdataX. MEM beats WB.
//   Refresh while holding: same priority against held out_rsX; x0 is never refreshed.
//   Writes to rd=0 are never forwarded. in_rs1==in_rs2 forwards both operands identically.
//   A flush asserted during a load-use stall clears the stage; no bubble is counted twice.
// TESTING
//   1 rst=1 for 2 clks, in_valid=1 -> out_valid=0, out_op1=out_op2=0, in_ready=0.
//   2 in rs1=5 rs2=6, rdata=0x11/0x22, ex_ready=1 -> next clk out_op1=0x11, out_op2=0x22, out_valid=1.
//   3 capture rs1=3, mem_rd=3 =0xAA, wb_rd=3 =0xBB -> out_op1=0xAA; rs1=0, mem_rd=0 -> out_op1=0.
//   4 held load rd=7, in rs2=7 -> load_use_stall=1, in_ready=0; next clk out_valid=0; then capture, operand via MEM.
//   5 ex_ready=0 holding rs1=9, wb_rd=9 =0x55 -> out_op1=0x55 next clk; other fields unchanged.
//   6 flush=1 with in_valid=1 and out_valid=1 -> next clk out_valid=0; incoming instruction never appears.

Source files
------------

// File: rtl/operand_stage.sv
// ============================================================================
// Module   : operand_stage
// Purpose  : Decode-to-execute pipeline register with MEM/WB operand
//            forwarding, stall-time operand refresh and load-use bubbles.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module operand_stage #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [4:0]   in_rs1,
  input  logic [4:0]   in_rs2,
  input  logic [4:0]   in_rd,
  input  logic         in_regwrite,
  input  logic         in_memread,
  input  logic [N-1:0] in_rdata1,
  input  logic [N-1:0] in_rdata2,
  input  logic         flush,
  input  logic         mem_regwrite,
  input  logic [4:0]   mem_rd,
  input  logic [N-1:0] mem_result,
  input  logic         wb_regwrite,
  input  logic [4:0]   wb_rd,
  input  logic [N-1:0] wb_result,
  input  logic         ex_ready,
  output logic         out_valid,
  output logic [4:0]   out_rs1,
  output logic [4:0]   out_rs2,
  output logic [4:0]   out_rd,
  output logic         out_regwrite,
  output logic         out_memread,
  output logic [N-1:0] out_op1,
  output logic [N-1:0] out_op2,
  output logic         load_use_stall
);

  localparam logic [4:0] c_x0 = 5'd0;

  logic         r_valid;
  logic [4:0]   r_rs1;
  logic [4:0]   r_rs2;
  logic [4:0]   r_rd;
  logic         r_regwrite;
  logic         r_memread;
  logic [N-1:0] r_op1;
  logic [N-1:0] r_op2;

  logic         w_load_use;
  logic         w_in_ready;
  logic         w_fire_in;
  logic         w_fire_out;
  logic [N-1:0] w_cap_op1;
  logic [N-1:0] w_cap_op2;
  logic [N-1:0] w_ref_op1;
  logic [N-1:0] w_ref_op2;

  // MEM beats WB; an x0 source never matches, so writes to x0 never forward.
  function automatic logic [N-1:0] f_bypass(input logic [4:0] rs, input logic [N-1:0] dflt);
    if (rs == c_x0)                      return dflt;
    else if (mem_regwrite && mem_rd == rs) return mem_result;
    else if (wb_regwrite && wb_rd == rs)   return wb_result;
    else                                   return dflt;
  endfunction

  assign w_load_use = r_valid && r_memread && (r_rd != c_x0) && in_valid &&
                      ((in_rs1 == r_rd) || (in_rs2 == r_rd));
  assign w_in_ready = (!r_valid || ex_ready) && !w_load_use && !flush && !rst;
  assign w_fire_in  = in_valid && w_in_ready;
  assign w_fire_out = r_valid && ex_ready;

  assign w_cap_op1 = (in_rs1 == c_x0) ? '0 : f_bypass(in_rs1, in_rdata1);
  assign w_cap_op2 = (in_rs2 == c_x0) ? '0 : f_bypass(in_rs2, in_rdata2);
  assign w_ref_op1 = f_bypass(r_rs1, r_op1);
  assign w_ref_op2 = f_bypass(r_rs2, r_op2);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_op1      <= '0;
      r_op2      <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_fire_in) begin
      r_valid    <= 1'b1;
      r_rs1      <= in_rs1;
      r_rs2      <= in_rs2;
      r_rd       <= in_rd;
      r_regwrite <= in_regwrite;
      r_memread  <= in_memread;
      r_op1      <= w_cap_op1;
      r_op2      <= w_cap_op2;
    end else if (w_fire_out) begin
      r_valid <= 1'b0;
    end else if (r_valid) begin
      // Stalled: pick up results that landed in MEM/WB after capture.
      r_op1 <= w_ref_op1;
      r_op2 <= w_ref_op2;
    end
  end

  assign in_ready       = w_in_ready;
  assign load_use_stall = w_load_use;
  assign out_valid      = r_valid;
  assign out_rs1        = r_rs1;
  assign out_rs2        = r_rs2;
  assign out_rd         = r_rd;
  assign out_regwrite   = r_regwrite;
  assign out_memread    = r_memread;
  assign out_op1        = r_op1;
  assign out_op2        = r_op2;

endmodule

`default_nettype wire

// File: tb/tb_operand_stage.sv
// ============================================================================
// Module   : tb_operand_stage
// Purpose  : Directed and short random stimulus for operand_stage, checked
//            every cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_operand_stage;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   in_rs1, in_rs2, in_rd;
  logic         in_regwrite, in_memread;
  logic [N-1:0] in_rdata1, in_rdata2;
  logic         flush;
  logic         mem_regwrite;
  logic [4:0]   mem_rd;
  logic [N-1:0] mem_result;
  logic         wb_regwrite;
  logic [4:0]   wb_rd;
  logic [N-1:0] wb_result;
  logic         ex_ready;
  logic         out_valid;
  logic [4:0]   out_rs1, out_rs2, out_rd;
  logic         out_regwrite, out_memread;
  logic [N-1:0] out_op1, out_op2;
  logic         load_use_stall;

  int total = 0;
  int bad   = 0;

  operand_stage #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_regwrite(in_regwrite), .in_memread(in_memread),
    .in_rdata1(in_rdata1), .in_rdata2(in_rdata2),
    .flush(flush),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_result(wb_result),
    .ex_ready(ex_ready),
    .out_valid(out_valid), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_regwrite(out_regwrite), .out_memread(out_memread),
    .out_op1(out_op1), .out_op2(out_op2),
    .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  // Model: the instruction currently held by the stage, if any.
  typedef struct {
    bit         valid;
    bit [4:0]   rs1, rs2, rd;
    bit         regwrite, memread;
    bit [N-1:0] op1, op2;
  } instr_t;

  instr_t held;

  // Value a source register reads as, given the results still in flight.
  function automatic bit [N-1:0] source_value(input bit [4:0] rs, input bit [N-1:0] fallback);
    bit         we  [2];
    bit [4:0]   dst [2];
    bit [N-1:0] val [2];
    we[0] = mem_regwrite; dst[0] = mem_rd; val[0] = mem_result;
    we[1] = wb_regwrite;  dst[1] = wb_rd;  val[1] = wb_result;
    if (rs == 0) return fallback;
    for (int k = 0; k < 2; k++)
      if (we[k] && dst[k] == rs) return val[k];
    return fallback;
  endfunction

  function automatic bit model_hazard();
    return held.valid && held.memread && held.rd != 0 && in_valid &&
           (in_rs1 == held.rd || in_rs2 == held.rd);
  endfunction

  function automatic bit model_ready();
    if (rst || flush || model_hazard()) return 1'b0;
    return !held.valid || ex_ready;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      held = '{default: 0};
    end else if (flush) begin
      held.valid = 1'b0;
    end else if (in_valid && model_ready()) begin
      held.valid    = 1'b1;
      held.rs1      = in_rs1;
      held.rs2      = in_rs2;
      held.rd       = in_rd;
      held.regwrite = in_regwrite;
      held.memread  = in_memread;
      held.op1      = (in_rs1 == 0) ? '0 : source_value(in_rs1, in_rdata1);
      held.op2      = (in_rs2 == 0) ? '0 : source_value(in_rs2, in_rdata2);
    end else if (held.valid && ex_ready) begin
      held.valid = 1'b0;
    end else if (held.valid) begin
      held.op1 = source_value(held.rs1, held.op1);
      held.op2 = source_value(held.rs2, held.op2);
    end
  end

  task automatic check(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    check("m_in_ready", {31'b0, in_ready}, {31'b0, model_ready()});
    check("m_stall", {31'b0, load_use_stall}, {31'b0, model_hazard()});
    check("m_valid", {31'b0, out_valid}, {31'b0, held.valid});
    if (held.valid) begin
      check("m_rs1", {27'b0, out_rs1}, {27'b0, held.rs1});
      check("m_rs2", {27'b0, out_rs2}, {27'b0, held.rs2});
      check("m_rd", {27'b0, out_rd}, {27'b0, held.rd});
      check("m_ctl", {30'b0, out_regwrite, out_memread}, {30'b0, held.regwrite, held.memread});
      check("m_op1", out_op1, held.op1);
      check("m_op2", out_op2, held.op2);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit [4:0] rs1, input bit [4:0] rs2, input bit [4:0] rd,
                        input bit rw, input bit mr, input bit [N-1:0] d1, input bit [N-1:0] d2);
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_regwrite = rw; in_memread = mr;
    in_rdata1 = d1; in_rdata2 = d2;
  endtask

  task automatic set_bypass(input bit mw, input bit [4:0] md, input bit [N-1:0] mv,
                            input bit ww, input bit [4:0] wd, input bit [N-1:0] wv);
    mem_regwrite = mw; mem_rd = md; mem_result = mv;
    wb_regwrite = ww; wb_rd = wd; wb_result = wv;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b0; in_valid = 1'b1;
    set_in(5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h1, 32'h2);
    set_bypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    tick(); tick();
    check("reset_valid", {31'b0, out_valid}, 32'd0);
    check("reset_op1", out_op1, 32'd0);
    check("reset_op2", out_op2, 32'd0);
    check("reset_ready", {31'b0, in_ready}, 32'd0);

    // Plain capture.
    rst = 1'b0; ex_ready = 1'b1;
    set_in(5'd5, 5'd6, 5'd1, 1'b1, 1'b0, 32'h11, 32'h22);
    tick();
    check("cap_valid", {31'b0, out_valid}, 32'd1);
    check("cap_op1", out_op1, 32'h11);
    check("cap_op2", out_op2, 32'h22);

    // MEM beats WB on the same register.
    set_in(5'd3, 5'd4, 5'd2, 1'b1, 1'b0, 32'h33, 32'h44);
    set_bypass(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
    tick();
    check("fwd_mem_op1", out_op1, 32'hAA);
    check("fwd_none_op2", out_op2, 32'h44);

    // x0 reads zero even with a write to x0 in MEM; WB forwards rs2.
    set_in(5'd0, 5'd3, 5'd2, 1'b1, 1'b0, 32'h99, 32'h44);
    set_bypass(1'b1, 5'd0, 32'hCC, 1'b1, 5'd3, 32'hBB);
    tick();
    check("x0_op1", out_op1, 32'd0);
    check("fwd_wb_op2", out_op2, 32'hBB);

    // Load-use: load to x7, then a consumer of x7.
    set_bypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    set_in(5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 32'h01, 32'h02);
    tick();
    check("load_memread", {31'b0, out_memread}, 32'd1);
    set_in(5'd8, 5'd7, 5'd9, 1'b1, 1'b0, 32'h88, 32'h77);
    #1;
    check("lu_stall", {31'b0, load_use_stall}, 32'd1);
    check("lu_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("lu_bubble", {31'b0, out_valid}, 32'd0);
    set_bypass(1'b1, 5'd7, 32'h700, 1'b0, 5'd0, '0);
    tick();
    check("lu_cap_valid", {31'b0, out_valid}, 32'd1);
    check("lu_cap_op2", out_op2, 32'h700);
    check("lu_cap_rd", {27'b0, out_rd}, 32'd9);

    // Refresh while stalled.
    set_bypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    set_in(5'd9, 5'd10, 5'd11, 1'b1, 1'b0, 32'h90, 32'hA0);
    tick();
    check("hold_cap_op1", out_op1, 32'h90);
    ex_ready = 1'b0; in_valid = 1'b0;
    set_bypass(1'b0, 5'd0, '0, 1'b1, 5'd9, 32'h55);
    tick();
    check("refresh_op1", out_op1, 32'h55);
    check("refresh_op2", out_op2, 32'hA0);
    check("refresh_rd", {27'b0, out_rd}, 32'd11);
    check("refresh_valid", {31'b0, out_valid}, 32'd1);

    // Flush kills held and incoming.
    set_bypass(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
    in_valid = 1'b1; flush = 1'b1;
    set_in(5'd12, 5'd13, 5'd14, 1'b1, 1'b0, 32'hC0, 32'hD0);
    #1;
    check("flush_ready", {31'b0, in_ready}, 32'd0);
    tick();
    check("flush_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("flush_dropped", {31'b0, out_valid}, 32'd0);

    // Flush during a load-use stall.
    ex_ready = 1'b1; in_valid = 1'b1;
    set_in(5'd1, 5'd2, 5'd6, 1'b1, 1'b1, 32'h1, 32'h2);
    tick();
    set_in(5'd6, 5'd6, 5'd3, 1'b1, 1'b0, 32'h66, 32'h66);
    flush = 1'b1;
    tick();
    check("flush_lu_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    #1;
    check("flush_lu_ready", {31'b0, in_ready}, 32'd1);
    tick();
    check("flush_lu_recap", out_op1, 32'h66);

    // Random traffic on a small register window to exercise collisions.
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'($urandom_range(0, 3) != 0);
      ex_ready = 1'($urandom_range(0, 2) != 0);
      flush    = 1'($urandom_range(0, 15) == 0);
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             1'($urandom), 1'($urandom), $urandom, $urandom);
      set_bypass(1'($urandom), 5'($urandom_range(0, 3)), $urandom,
                 1'($urandom), 5'($urandom_range(0, 3)), $urandom);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
